arbn: RTL

ARBN -- requirements
Module: arbn

---
 rtl/arbn_if.sv | 38 +++
 rtl/arbn.sv | 125 ++++++++++++
 2 files changed

// File: rtl/arbn_if.sv
// rtl/arbn_if.sv - requester/downstream bus bundle for the arbn arbiter
// Ports (signals):
//   req_valid/req_addr/req_wdata/req_wstrb : per-port requests, 32-bit slices packed by port index
//   req_ready/req_rdata                     : per-port completion pulse and shared read data
//   mem_valid/mem_addr/mem_wdata/mem_wstrb  : downstream request
//   mem_ready/mem_rdata                     : downstream completion and read data
//   grant/timeout_err                       : one-hot bus owner, watchdog pulse
// modport slave is the arbiter side, modport master is the requester/memory side.
interface arbn_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]    req_valid;
  logic [NPORTS-1:0]    req_ready;
  logic [32*NPORTS-1:0] req_addr;
  logic [32*NPORTS-1:0] req_wdata;
  logic [4*NPORTS-1:0]  req_wstrb;
  logic [31:0]          req_rdata;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [31:0]          mem_rdata;
  logic [NPORTS-1:0]    grant;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           grant, timeout_err
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           grant, timeout_err
  );
endinterface

// File: rtl/arbn.sv
// rtl/arbn.sv - N-port request arbiter onto a single downstream memory bus
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : arbn_if.slave bundle (requests in, downstream request out, grant, watchdog)
// Parameters: NPORTS (2..8), MODE (0 fixed priority, 1 round-robin),
//             TIMEOUT (downstream watchdog in cycles, 0 disables).
module arbn #(
  parameter int NPORTS  = 2,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic    clk,
  input  logic    rst,
  arbn_if.slave   bus
);
  localparam int IW = $clog2(NPORTS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;
  logic [NPORTS-1:0] r_grant;

  logic [IW-1:0]     w_win;
  logic              w_any;
  logic              w_own_valid;
  logic              w_tmo_hit;

  assign w_any       = |bus.req_valid;
  assign w_own_valid = bus.req_valid[r_owner];
  assign w_tmo_hit   = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));

  // Winner selection. Round-robin scans upward starting one past the last
  // granted port, so the previous owner is considered last.
  always_comb begin : p_win
    int p;
    logic found;
    w_win = '0;
    found = 1'b0;
    p     = 0;
    if (MODE == 0) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) w_win = IW'(i);
      end
    end else begin
      for (int j = 1; j <= NPORTS; j++) begin
        p = (int'(r_ptr) + j) % NPORTS;
        if (!found && bus.req_valid[p]) begin
          w_win = IW'(p);
          found = 1'b1;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= IW'(NPORTS - 1);
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_owner <= w_win;
          r_ptr   <= w_win;
          r_grant <= NPORTS'(1) << w_win;
        end
        r_cnt <= '0;
      end else if (w_next == S_IDLE) begin
        r_grant <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next state: a withdrawn request, a completion or the watchdog all end BUSY
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_BUSY;
      S_BUSY: if (!w_own_valid || bus.mem_ready || w_tmo_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are held at zero while rst is high so nothing leaks out of an
  // abandoned transaction in the reset cycle itself.
  always_comb begin
    bus.grant       = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wstrb   = '0;
    bus.req_ready   = '0;
    bus.req_rdata   = '0;
    bus.timeout_err = 1'b0;
    if (!rst && r_state == S_BUSY) begin
      bus.grant     = r_grant;
      bus.mem_valid = w_own_valid;
      bus.mem_addr  = bus.req_addr[32*r_owner +: 32];
      bus.mem_wdata = bus.req_wdata[32*r_owner +: 32];
      bus.mem_wstrb = bus.req_wstrb[4*r_owner +: 4];
      if (w_own_valid) begin
        // mem_ready takes precedence over a coincident watchdog expiry
        if (bus.mem_ready) begin
          bus.req_ready[r_owner] = 1'b1;
          bus.req_rdata          = bus.mem_rdata;
        end else if (w_tmo_hit) begin
          bus.req_ready[r_owner] = 1'b1;
          bus.timeout_err        = 1'b1;
        end
      end
    end
  end
endmodule
